// File: rtl/shift_ctrl_pkg.sv
// Shared constants for the shift-counter controller:
// command op-codes, FSM state encoding, direction and mode values.
package shift_ctrl_pkg;

   localparam logic [1:0] OP_RUN   = 2'b00;
   localparam logic [1:0] OP_LOAD  = 2'b01;
   localparam logic [1:0] OP_STOP  = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   localparam logic DIR_LEFT     = 1'b0;
   localparam logic DIR_RIGHT    = 1'b1;
   localparam logic MODE_RING    = 1'b0;
   localparam logic MODE_JOHNSON = 1'b1;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_e;

endpackage

// File: rtl/shift_datapath.sv
// WIDTH-bit ring/Johnson shift register with clear, load and shift enable.
// Ports: i_clk, i_rst_n, i_load/i_data, i_clear, i_shift, i_dir, i_mode, o_count.
module shift_datapath
   import shift_ctrl_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_load,
   input  logic             i_clear,
   input  logic             i_shift,
   input  logic             i_dir,
   input  logic             i_mode,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_count
);

   localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(1);

   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] w_shifted;

   // XOR with mode: ring feeds the bit back unchanged, Johnson inverts it.
   always_comb begin
      w_shifted = r_count;
      if (i_dir == DIR_LEFT)
         w_shifted = {r_count[WIDTH-2:0], r_count[WIDTH-1] ^ i_mode};
      else
         w_shifted = {r_count[0] ^ i_mode, r_count[WIDTH-1:1]};
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_count <= RST_VAL;
      else if (i_clear)
         r_count <= '0;
      else if (i_load)
         r_count <= i_data;
      else if (i_shift)
         r_count <= w_shifted;
   end

   assign o_count = r_count;

endmodule

// File: rtl/shift_counter_ctrl.sv
// Command-driven sequencer for the shift datapath: steps, prescaler, done pulse.
// Ports: p_clk_in, p_rst, cmd_* handshake/fields, count, steps_left, busy, done.
module shift_counter_ctrl
   import shift_ctrl_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int STEP_W = 8,
   parameter int PRE_W  = 4
) (
   input  logic              p_clk_in,
   input  logic              p_rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic              cmd_dir,
   input  logic              cmd_mode,
   input  logic [STEP_W-1:0] cmd_steps,
   input  logic [PRE_W-1:0]  cmd_prescale,
   input  logic [WIDTH-1:0]  cmd_data,
   output logic [WIDTH-1:0]  count,
   output logic [STEP_W-1:0] steps_left,
   output logic              busy,
   output logic              done
);

   state_e            r_state;
   state_e            w_next;
   logic [STEP_W-1:0] r_steps;
   logic [PRE_W-1:0]  r_presc_cnt;
   logic [PRE_W-1:0]  r_prescale;
   logic              r_dir;
   logic              r_mode;

   logic w_acc;
   logic w_start;
   logic w_load;
   logic w_clear;
   logic w_shift;

   // RUN/LOAD during RUN stall on ready; only STOP/CLEAR may preempt.
   always_comb begin
      cmd_ready = 1'b0;
      unique case (r_state)
         S_IDLE:  cmd_ready = 1'b1;
         S_RUN:   cmd_ready = (cmd_op == OP_STOP) || (cmd_op == OP_CLEAR);
         default: cmd_ready = 1'b0;
      endcase
   end

   assign w_acc = cmd_valid && cmd_ready;

   always_comb begin
      w_next  = r_state;
      w_start = 1'b0;
      w_load  = 1'b0;
      w_clear = 1'b0;
      w_shift = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_acc) begin
               unique case (cmd_op)
                  OP_RUN: begin
                     w_start = 1'b1;
                     w_next  = (cmd_steps == '0) ? S_DONE : S_RUN;
                  end
                  OP_LOAD:  w_load  = 1'b1;
                  OP_CLEAR: w_clear = 1'b1;
                  default:  ;
               endcase
            end
         end
         S_RUN: begin
            if (w_acc) begin
               w_next  = S_IDLE;
               w_clear = (cmd_op == OP_CLEAR);
            end else if (r_presc_cnt == '0 && r_steps != '0) begin
               w_shift = 1'b1;
               if (r_steps == STEP_W'(1))
                  w_next = S_DONE;
            end
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge p_clk_in or negedge p_rst) begin
      if (!p_rst) begin
         r_state     <= S_IDLE;
         r_steps     <= '0;
         r_presc_cnt <= '0;
         r_prescale  <= '0;
         r_dir       <= DIR_LEFT;
         r_mode      <= MODE_RING;
      end else begin
         r_state <= w_next;
         if (w_start) begin
            r_steps     <= cmd_steps;
            r_presc_cnt <= cmd_prescale;
            r_prescale  <= cmd_prescale;
            r_dir       <= cmd_dir;
            r_mode      <= cmd_mode;
         end else if (w_clear) begin
            r_steps <= '0;
         end else if (r_state == S_RUN && !w_acc) begin
            if (r_presc_cnt == '0) begin
               r_presc_cnt <= r_prescale;
               if (r_steps != '0)
                  r_steps <= r_steps - STEP_W'(1);
            end else begin
               r_presc_cnt <= r_presc_cnt - PRE_W'(1);
            end
         end
      end
   end

   shift_datapath #(
      .WIDTH (WIDTH)
   ) u_dp (
      .i_clk   (p_clk_in),
      .i_rst_n (p_rst),
      .i_load  (w_load),
      .i_clear (w_clear),
      .i_shift (w_shift),
      .i_dir   (r_dir),
      .i_mode  (r_mode),
      .i_data  (cmd_data),
      .o_count (count)
   );

   assign steps_left = r_steps;
   assign busy       = (r_state == S_RUN);
   assign done       = (r_state == S_DONE);

endmodule

// File: doc/shift_counter_ctrl.md
Name: shift_counter_ctrl

Overview:
Command-driven controller that sequences an 8-bit shift-counter datapath (ring or Johnson, left or right) for a programmed number of steps at a programmable rate. It accepts commands over a valid/ready handshake, owns the count register, and signals completion with a one-cycle pulse. It sits between a host/sequencer and any logic that consumes the shifting count pattern.

Parameters:
WIDTH, 8, count register width (>=2)
STEP_W, 8, width of step counter / cmd_steps
PRE_W, 4, width of prescale value

Ports:
p_clk_in  input  1  single clock, rising edge
p_rst  input  1  asynchronous, active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  command accepted this cycle when valid&ready
cmd_op  input  2  00 RUN, 01 LOAD, 10 STOP, 11 CLEAR
cmd_dir  input  1  0 shift left (toward MSB), 1 shift right
cmd_mode  input  1  0 ring, 1 Johnson (inverted feedback)
cmd_steps  input  STEP_W  number of shifts for RUN
cmd_prescale  input  PRE_W  shift every cmd_prescale+1 cycles
cmd_data  input  WIDTH  value for LOAD
count  output  WIDTH  current count register
steps_left  output  STEP_W  remaining shifts in current/last RUN
busy  output  1  high in RUN
done  output  1  one-cycle pulse when RUN completes all steps

Behaviour:
- Reset (p_rst=0, async): state=IDLE, count=1 (LSB set), steps_left=0, presc_cnt=0, dir/mode regs=0, done=0, busy=0.
- States: IDLE, RUN, DONE. busy=1 only in RUN; done=1 only in DONE (registered, exactly one cycle).
- cmd_ready (combinational): 1 in IDLE for any op; 1 in RUN only when cmd_op is STOP or CLEAR; 0 in DONE. RUN/LOAD presented during RUN are stalled (not dropped).
- IDLE, accept RUN: latch dir, mode, prescale; steps_left<=cmd_steps; presc_cnt<=cmd_prescale; if cmd_steps==0 go DONE (no shift) else go RUN.
- IDLE, accept LOAD: count<=cmd_data at accept edge; stay IDLE; no done.
- IDLE, accept STOP: no-op. CLEAR (IDLE or RUN): count<=0, steps_left<=0, go IDLE, no done.
- RUN each cycle: if presc_cnt==0 -> shift count, steps_left<=steps_left-1, presc_cnt<=prescale; if steps_left==1 go DONE. Else presc_cnt<=presc_cnt-1.
- First shift occurs prescale+1 edges after accept edge; successive shifts prescale+1 cycles apart; done asserted the cycle after the final shift edge.
- Shift rules: ring left {c[W-2:0],c[W-1]}; ring right {c[0],c[W-1:1]}; Johnson left {c[W-2:0],~c[W-1]}; Johnson right {~c[0],c[W-1:1]}. Wrap-around is inherent; all-zero ring stays zero.
- RUN, accept STOP: go IDLE at that edge, count and steps_left hold, no shift that edge, no done.
- DONE: go IDLE next edge; count holds.
- Reset asserted mid-RUN: immediate return to reset values; no done pulse.
- steps_left never underflows; cmd_* sampled only at accept edge.

Decomposition:
- Package shift_ctrl_pkg: op-code constants (OP_RUN, OP_LOAD, OP_STOP, OP_CLEAR), state encoding (IDLE/RUN/DONE), DIR_LEFT/DIR_RIGHT, MODE_RING/MODE_JOHNSON.
- Sub-module shift_datapath: WIDTH register with load, clear, shift_en, dir, mode inputs, async active-low reset to 1; the controller FSM, prescaler and step counter stay in shift_counter_ctrl.

Test Plan:
- Reset then idle -> count=0x01, steps_left=0, busy=0, done=0, cmd_ready=1.
- LOAD 0x01; RUN ring left steps=3 prescale=0 -> count 0x02,0x04,0x08 on 3 consecutive edges, done pulse 1 cycle after 0x08, busy low after.
- CLEAR; RUN Johnson left steps=9 prescale=0 -> count 01,03,07,0F,1F,3F,7F,FF,FE, then done.
- LOAD 0x01; RUN ring right steps=2 prescale=2 -> 0x80 at accept+3 edges, 0x40 at accept+6, done at accept+7; RUN steps=0 -> done next cycle, count unchanged.
- RUN steps=10 prescale=0, STOP after 4 shifts -> count held at 0x10 (from 0x01 ring left), steps_left=6, no done; RUN presented while busy -> cmd_ready=0 until STOP.
- Assert p_rst low mid-RUN (async, between edges) -> count=0x01, state IDLE immediately, no done pulse after release.
